ovl_parity_check_sched: RTL and testbench

Round-robin scheduler that shares one ovl_odd_parity checker instance between num_req requesters. It captures a granted requester's word and drives the shared checker's enable and test_expr. It tags each check in flight and attributes the checker's fire[0] back to the originating requester as a sticky flag plus a saturating error count. It also provides pause/drain sequencing so software can quiesce the shared checker.

---
 rtl/ovl_parity_check_sched_pkg.sv | 24 ++
 rtl/ovl_parity_check_sched_if.sv | 24 ++
 rtl/ovl_parity_check_sched_rr_arbiter.sv | 31 +++
 rtl/ovl_parity_check_sched.sv | 157 +++++++++++++++
 tb/tb_ovl_parity_check_sched.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ovl_parity_check_sched_pkg.sv
// Shared types and helpers for the parity-check scheduler.
// Scheduler state encoding and one-hot decode.
package ovl_parity_sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_PAUSED
  } sched_state_t;

  localparam int FIRE_ASSERT_BIT = 0;
  localparam int MAX_REQ = 16;

  function automatic logic [3:0] onehot_to_idx(
    input logic [MAX_REQ-1:0] oh
  );
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = idx | 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/ovl_parity_check_sched_if.sv
// Requester-side bus of the parity-check scheduler.
// Requesters drive req/data, the scheduler returns gnt.
interface ovl_parity_check_sched_if #(
  parameter int num_req = 4,
  parameter int width   = 8
) ();

  logic [num_req-1:0]       req;
  logic [num_req*width-1:0] data;
  logic [num_req-1:0]       gnt;

  modport master (
    output req,
    output data,
    input  gnt
  );

  modport slave (
    input  req,
    input  data,
    output gnt
  );

endinterface

// File: rtl/ovl_parity_check_sched_rr_arbiter.sv
// Combinational round-robin pick over an eligible mask.
// Search starts at ptr and wraps; ptr storage lives in the parent.
module ovl_rr_arbiter #(
  parameter int num_req = 4,
  localparam int iw = $clog2(num_req)
) (
  input  logic [num_req-1:0] elig,
  input  logic [iw-1:0]      ptr,
  output logic [num_req-1:0] win_oh,
  output logic [iw-1:0]      win_idx,
  output logic               any
);

  import ovl_parity_sched_pkg::*;

  always_comb begin
    logic [iw-1:0] c;
    c      = '0;
    win_oh = '0;
    any    = 1'b0;
    for (int k = 0; k < num_req; k++) begin
      c = iw'((int'(ptr) + k) % num_req);
      if (!any && elig[c]) begin
        any       = 1'b1;
        win_oh[c] = 1'b1;
      end
    end
    win_idx = iw'(onehot_to_idx(16'(win_oh)));
  end

endmodule

// File: rtl/ovl_parity_check_sched.sv
// Shares one odd-parity checker between requesters,
// attributing its fires back to the requester that was checked.
module ovl_parity_check_sched #(
  parameter int num_req     = 4,
  parameter int width       = 8,
  parameter int chk_latency = 1,
  parameter int cnt_width   = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  ovl_parity_check_sched_if.slave        bus,
  input  logic [num_req-1:0]             req_mask,
  input  logic                           pause,
  input  logic                           clear_err,
  output logic                           chk_enable,
  output logic [width-1:0]               chk_test_expr,
  input  logic [2:0]                     fire_in,
  output logic [num_req-1:0]             err_sticky,
  output logic [num_req*cnt_width-1:0]   err_cnt,
  output logic                           stray_fire,
  output logic                           idle,
  output logic                           paused
);

  import ovl_parity_sched_pkg::*;

  localparam int iw = $clog2(num_req);
  localparam logic [cnt_width-1:0] CNT_MAX = '1;

  sched_state_t state;
  logic [iw-1:0] ptr_q;
  logic [iw-1:0] cur_idx;
  logic [num_req-1:0] elig;
  logic [num_req-1:0] win_oh;
  logic [iw-1:0] win_idx;
  logic any;
  logic do_grant;

  logic [chk_latency-1:0] tag_v;
  logic [chk_latency-1:0][iw-1:0] tag_id;
  logic last_v;
  logic [iw-1:0] last_id;

  logic [num_req-1:0][cnt_width-1:0] cnt_q;
  logic [num_req-1:0][cnt_width-1:0] cnt_d;
  logic [num_req-1:0] sticky_d;
  logic stray_d;
  logic fire_a;
  logic unused_fire;

  assign fire_a      = fire_in[FIRE_ASSERT_BIT];
  assign unused_fire = ^fire_in[2:1];

  // The in-flight grant is excluded so it cannot win twice.
  assign elig = bus.req & ~req_mask & ~bus.gnt;

  ovl_rr_arbiter #(.num_req(num_req)) u_arb (
    .elig    (elig),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (any)
  );

  assign do_grant = any && !pause &&
    (state == ST_RUN || state == ST_PAUSED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_RUN;
      bus.gnt       <= '0;
      chk_enable    <= 1'b0;
      chk_test_expr <= '0;
      ptr_q         <= '0;
      cur_idx       <= '0;
      paused        <= 1'b0;
    end else begin
      bus.gnt    <= '0;
      chk_enable <= 1'b0;
      unique case (state)
        ST_RUN: begin
          if (pause) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!pause) begin
            state <= ST_RUN;
          end else if (tag_v == '0 && bus.gnt == '0) begin
            state  <= ST_PAUSED;
            paused <= 1'b1;
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state  <= ST_RUN;
            paused <= 1'b0;
          end
        end
        default: state <= ST_RUN;
      endcase
      if (do_grant) begin
        bus.gnt       <= win_oh;
        chk_enable    <= 1'b1;
        chk_test_expr <= bus.data[win_idx*width +: width];
        cur_idx       <= win_idx;
        ptr_q <= (win_idx == iw'(num_req-1)) ?
          '0 : win_idx + iw'(1);
      end
    end
  end

  // Stage 0 loads on the edge where the checker samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= chk_enable;
      tag_id[0] <= cur_idx;
      for (int s = 1; s < chk_latency; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  assign last_v  = tag_v[chk_latency-1];
  assign last_id = tag_id[chk_latency-1];

  // Clear first, then the coincident error lands on top.
  always_comb begin
    sticky_d = clear_err ? '0 : err_sticky;
    cnt_d    = clear_err ? '0 : cnt_q;
    stray_d  = clear_err ? 1'b0 : stray_fire;
    if (fire_a && last_v) begin
      sticky_d[last_id] = 1'b1;
      if (cnt_d[last_id] != CNT_MAX)
        cnt_d[last_id] = cnt_d[last_id] + cnt_width'(1);
    end
    if (fire_a && !last_v) stray_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_sticky <= '0;
      cnt_q      <= '0;
      stray_fire <= 1'b0;
    end else begin
      err_sticky <= sticky_d;
      cnt_q      <= cnt_d;
      stray_fire <= stray_d;
    end
  end

  assign err_cnt = cnt_q;
  assign idle    = (bus.gnt == '0) && (tag_v == '0);

endmodule

// File: tb/tb_ovl_parity_check_sched.sv
// Directed bench for ovl_parity_check_sched with an
// odd-parity checker model of latency 1.
module tb_ovl_parity_check_sched;

  logic        clock;
  logic        reset;
  logic [3:0]  req_mask;
  logic        pause;
  logic        clear_err;
  logic        chk_enable;
  logic [7:0]  chk_test_expr;
  logic [2:0]  fire_in;
  logic [3:0]  err_sticky;
  logic [31:0] err_cnt;
  logic        stray_fire;
  logic        idle;
  logic        paused;

  logic       fire_q;
  logic       fire_force;
  logic [1:0] fire_hi;

  int n_checks;
  int n_errors;

  ovl_parity_check_sched_if #(.num_req(4), .width(8)) bus ();

  ovl_parity_check_sched #(
    .num_req(4), .width(8), .chk_latency(1), .cnt_width(8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .req_mask      (req_mask),
    .pause         (pause),
    .clear_err     (clear_err),
    .chk_enable    (chk_enable),
    .chk_test_expr (chk_test_expr),
    .fire_in       (fire_in),
    .err_sticky    (err_sticky),
    .err_cnt       (err_cnt),
    .stray_fire    (stray_fire),
    .idle          (idle),
    .paused        (paused)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Odd-parity checker: fires one cycle after sampling an even word.
  always @(posedge clock or posedge reset) begin
    if (reset) fire_q <= 1'b0;
    else fire_q <= chk_enable && !(^chk_test_expr);
  end

  assign fire_in = {fire_hi, fire_q | fire_force};

  task automatic check(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    bus.req = bus.req & ~bus.gnt;
  endtask

  task automatic set_word(input int i, input logic [7:0] v);
    bus.data[i*8 +: 8] = v;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.req    = '0;
    bus.data   = {4{8'h01}};
    req_mask   = '0;
    pause      = 1'b0;
    clear_err  = 1'b0;
    fire_force = 1'b0;
    fire_hi    = 2'b00;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    do_reset();
    check("rst_gnt", 64'(bus.gnt), 64'h0);
    check("rst_en", 64'(chk_enable), 64'h0);
    check("rst_expr", 64'(chk_test_expr), 64'h0);
    check("rst_idle", 64'(idle), 64'h1);
    check("rst_paused", 64'(paused), 64'h0);
    check("rst_cnt", 64'(err_cnt), 64'h0);

    // single clean check, upper fire bits ignored
    fire_hi = 2'b11;
    set_word(0, 8'h01);
    bus.req = 4'b0001;
    tick();
    check("t1_gnt", 64'(bus.gnt), 64'h1);
    check("t1_en", 64'(chk_enable), 64'h1);
    check("t1_expr", 64'(chk_test_expr), 64'h01);
    tick();
    check("t1_en_off", 64'(chk_enable), 64'h0);
    check("t1_busy", 64'(idle), 64'h0);
    tick();
    check("t1_idle", 64'(idle), 64'h1);
    check("t1_sticky", 64'(err_sticky), 64'h0);
    check("t1_stray", 64'(stray_fire), 64'h0);

    // round robin sweep
    do_reset();
    bus.req = 4'b1111;
    tick();
    check("rr_g0", 64'(bus.gnt), 64'h1);
    tick();
    check("rr_g1", 64'(bus.gnt), 64'h2);
    tick();
    check("rr_g2", 64'(bus.gnt), 64'h4);
    tick();
    check("rr_g3", 64'(bus.gnt), 64'h8);
    tick();
    check("rr_end", 64'(bus.gnt), 64'h0);
    check("rr_ptr", 64'(dut.ptr_q), 64'h0);

    // even parity on requester 2, then masked
    do_reset();
    set_word(2, 8'h03);
    bus.req = 4'b0100;
    tick();
    check("p_gnt", 64'(bus.gnt), 64'h4);
    check("p_expr", 64'(chk_test_expr), 64'h03);
    tick();
    tick();
    check("p_sticky", 64'(err_sticky), 64'h4);
    check("p_cnt", 64'(err_cnt), 64'h0001_0000);
    req_mask = 4'b0100;
    bus.req  = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mask_gnt", 64'(bus.gnt), 64'h0);
    end

    // saturation and clear coincident with an error
    do_reset();
    set_word(1, 8'h03);
    for (int i = 0; i < 300; i++) begin
      bus.req = 4'b0010;
      tick();
      tick();
    end
    tick();
    tick();
    check("sat_cnt", 64'(err_cnt), 64'h0000_ff00);
    check("sat_sticky", 64'(err_sticky), 64'h2);
    bus.req = 4'b0010;
    tick();
    tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("clr_sticky", 64'(err_sticky), 64'h2);
    check("clr_cnt", 64'(err_cnt), 64'h0000_0100);

    // pause and drain with two checks in flight
    do_reset();
    set_word(0, 8'h03);
    set_word(1, 8'h03);
    set_word(3, 8'h01);
    bus.req = 4'b0011;
    tick();
    check("pz_g0", 64'(bus.gnt), 64'h1);
    tick();
    check("pz_g1", 64'(bus.gnt), 64'h2);
    pause   = 1'b1;
    bus.req = bus.req | 4'b1000;
    tick();
    check("pz_nogrant", 64'(bus.gnt), 64'h0);
    tick();
    check("pz_sticky", 64'(err_sticky), 64'h3);
    check("pz_draining", 64'(paused), 64'h0);
    tick();
    check("pz_paused", 64'(paused), 64'h1);
    check("pz_idle", 64'(idle), 64'h1);
    tick();
    check("pz_hold", 64'(bus.gnt), 64'h0);
    check("pz_en", 64'(chk_enable), 64'h0);
    pause = 1'b0;
    tick();
    check("pz_resume", 64'(bus.gnt), 64'h8);
    check("pz_unpaused", 64'(paused), 64'h0);
    check("pz_cnt", 64'(err_cnt), 64'h0000_0101);

    // asynchronous reset mid-burst, then a stray fire
    do_reset();
    bus.req = 4'b1111;
    tick();
    tick();
    #2;
    reset   = 1'b1;
    bus.req = '0;
    #1;
    check("ar_gnt", 64'(bus.gnt), 64'h0);
    check("ar_en", 64'(chk_enable), 64'h0);
    check("ar_expr", 64'(chk_test_expr), 64'h0);
    check("ar_idle", 64'(idle), 64'h1);
    #4;
    reset = 1'b0;
    tick();
    fire_force = 1'b1;
    tick();
    fire_force = 1'b0;
    check("stray_set", 64'(stray_fire), 64'h1);
    check("stray_sticky", 64'(err_sticky), 64'h0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("stray_clr", 64'(stray_fire), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors",
      n_checks, n_errors);
    $finish;
  end

endmodule
